// File: rtl/sqrt2_host.sv
// sqrt2_host: FIFO-buffered bus master for the sqrt2 FP16 square-root core.
// Each operand runs one LOAD / WAIT / RELEASE transaction on the shared data bus.
module sqrt2_host #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic [3:0]  out_flags,
  output logic        busy,
  output logic        sq_enable,
  inout  wire  [15:0] sq_data,
  input  logic        sq_result,
  input  logic        sq_is_nan,
  input  logic        sq_is_pinf,
  input  logic        sq_is_ninf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t          state_r;
  logic [15:0]     fifo_mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_nxt_s;
  logic            in_ready_r;
  logic [15:0]     op_r;
  logic            drive_r;
  logic            enable_r;
  logic [TW-1:0]   wait_cnt_r;
  logic            out_valid_r;
  logic [15:0]     out_data_r;
  logic [3:0]      out_flags_r;
  logic            busy_r;
  logic            push_s;
  logic            launch_s;
  logic            done_s;
  logic            timeout_s;

  // Result encoding by priority; no done indication means the timeout code.
  function automatic logic [19:0] capture_code(
    input logic        res,
    input logic        nan,
    input logic        pinf,
    input logic        ninf,
    input logic [15:0] bus
  );
    if (res) begin
      capture_code = {4'b0000, bus};
    end else if (nan) begin
      capture_code = {4'b0001, 16'h7E00};
    end else if (pinf) begin
      capture_code = {4'b0010, 16'h7C00};
    end else if (ninf) begin
      capture_code = {4'b0100, 16'hFC00};
    end else begin
      capture_code = {4'b1000, 16'h7E00};
    end
  endfunction

  // Handshake decode and next FIFO occupancy.
  always_comb begin
    push_s      = in_valid & in_ready_r;
    launch_s    = (state_r == ST_IDLE) && (count_r != {CW{1'b0}}) && (!out_valid_r || out_ready);
    done_s      = sq_result | sq_is_nan | sq_is_pinf | sq_is_ninf;
    timeout_s   = (wait_cnt_r == TW'(TIMEOUT - 1));
    count_nxt_s = count_r;
    if (push_s && !launch_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (!push_s && launch_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Operand storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= in_data;
    end
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      in_ready_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (launch_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r    <= count_nxt_s;
      in_ready_r <= (count_nxt_s != CW'(DEPTH));
    end
  end

  // Transaction FSM with registered bus controls and output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      op_r        <= 16'h0000;
      drive_r     <= 1'b0;
      enable_r    <= 1'b0;
      wait_cnt_r  <= {TW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= 16'h0000;
      out_flags_r <= 4'b0000;
      busy_r      <= 1'b0;
    end else begin
      if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (launch_s) begin
            state_r  <= ST_LOAD;
            op_r     <= fifo_mem_r[rd_ptr_r];
            drive_r  <= 1'b1;
            enable_r <= 1'b1;
            busy_r   <= 1'b1;
          end else begin
            busy_r   <= (count_nxt_s != {CW{1'b0}});
          end
        end
        ST_LOAD: begin
          state_r    <= ST_WAIT;
          drive_r    <= 1'b0;
          wait_cnt_r <= {TW{1'b0}};
          busy_r     <= 1'b1;
        end
        ST_WAIT: begin
          // The launch condition guarantees the output slot is free here.
          if (done_s || timeout_s) begin
            {out_flags_r, out_data_r} <= capture_code(sq_result, sq_is_nan, sq_is_pinf,
                                                      sq_is_ninf, sq_data);
            out_valid_r <= 1'b1;
            enable_r    <= 1'b0;
            state_r     <= ST_RELEASE;
          end else begin
            wait_cnt_r  <= wait_cnt_r + TW'(1);
          end
        end
        ST_RELEASE: begin
          state_r <= ST_IDLE;
          busy_r  <= (count_nxt_s != {CW{1'b0}});
        end
        default: begin
          state_r  <= ST_IDLE;
          drive_r  <= 1'b0;
          enable_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_flags = out_flags_r;
  assign busy      = busy_r;
  assign sq_enable = enable_r;
  // Gating with rst_n releases the bus the instant reset asserts.
  assign sq_data   = (drive_r && rst_n) ? op_r : 16'hzzzz;

endmodule

// File: tb/tb_sqrt2_host.sv
// tb_sqrt2_host: scoreboard bench for sqrt2_host with a behavioural sqrt2 core model
// answering on the shared bus.
module tb_sqrt2_host;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [3:0]  out_flags;
  logic        busy;
  logic        sq_enable;
  wire  [15:0] sq_data;
  logic        sq_result, sq_is_nan, sq_is_pinf, sq_is_ninf;

  logic        model_drive;
  logic [15:0] model_data;
  logic [15:0] model_op;
  int          model_cd;
  bit          model_silent = 1'b0;
  int          model_lat = 3;
  int          loads = 0;
  int          dut_drive_cnt = 0;

  int          checks = 0;
  int          failures = 0;
  int          push_lost = 0;
  logic [19:0] exp_q [$];

  assign sq_data = model_drive ? model_data : 16'hzzzz;

  sqrt2_host #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
    .busy(busy), .sq_enable(sq_enable), .sq_data(sq_data),
    .sq_result(sq_result), .sq_is_nan(sq_is_nan), .sq_is_pinf(sq_is_pinf), .sq_is_ninf(sq_is_ninf)
  );

  always #5 clk = ~clk;

  function automatic bit bus_idle(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  function automatic logic [15:0] sqrt_tab(input logic [15:0] op);
    case (op)
      16'h4400: return 16'h4000;
      16'h4C00: return 16'h4400;
      16'h3C00: return 16'h3C00;
      16'h5400: return 16'h4800;
      16'h5C00: return 16'h4C00;
      16'h4000: return 16'h3DA8;
      default:  return 16'h3C00;
    endcase
  endfunction

  function automatic logic [19:0] expect_of(input logic [15:0] op);
    if (op == 16'h7C00) return {4'b0010, 16'h7C00};
    if (op == 16'hFC00) return {4'b0100, 16'hFC00};
    if (op[15] || op[14:10] == 5'h1F) return {4'b0001, 16'h7E00};
    return {4'b0000, sqrt_tab(op)};
  endfunction

  // Core model: latches the operand in the LOAD cycle, answers model_lat cycles later.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_drive <= 1'b0; model_data <= 16'h0000; model_cd <= 0;
      sq_result <= 1'b0; sq_is_nan <= 1'b0; sq_is_pinf <= 1'b0; sq_is_ninf <= 1'b0;
    end else begin
      model_drive <= 1'b0;
      sq_result <= 1'b0; sq_is_nan <= 1'b0; sq_is_pinf <= 1'b0; sq_is_ninf <= 1'b0;
      if (model_cd != 0) begin
        model_cd <= model_cd - 1;
        if (model_cd == 1) begin
          if (model_op == 16'h7C00) sq_is_pinf <= 1'b1;
          else if (model_op == 16'hFC00) sq_is_ninf <= 1'b1;
          else if (model_op[15] || model_op[14:10] == 5'h1F) sq_is_nan <= 1'b1;
          else begin
            sq_result <= 1'b1; model_drive <= 1'b1; model_data <= sqrt_tab(model_op);
          end
        end
      end else if (sq_enable && !model_drive && !bus_idle(sq_data)) begin
        model_op <= sq_data;
        loads <= loads + 1;
        if (!model_silent) model_cd <= model_lat;
      end
    end
  end

  always @(negedge clk) begin
    if (!model_drive && !bus_idle(sq_data)) dut_drive_cnt <= dut_drive_cnt + 1;
  end

  task automatic push_one(input logic [15:0] v, input logic [19:0] e);
    bit done = 1'b0;
    in_valid = 1'b1; in_data = v;
    for (int c = 0; c < 100 && !done; c++) begin
      if (in_ready) begin done = 1'b1; exp_q.push_back(e); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) push_lost++;
  endtask

  task automatic wait_out(output bit ok, output logic [19:0] obs);
    ok = 1'b0; obs = 20'h0;
    for (int c = 0; c < 400 && !ok; c++) begin
      if (out_valid && out_ready) begin ok = 1'b1; obs = {out_flags, out_data}; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, sq_enable} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 0000", {in_ready, out_valid, busy, sq_enable});
    end
    checks++;
    if ({out_flags, out_data} !== 20'h0) begin
      failures++; $display("FAIL reset_data: got %h expected 00000", {out_flags, out_data});
    end
    checks++;
    if (!bus_idle(sq_data)) begin
      failures++; $display("FAIL reset_bus: got %h expected Z", sq_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL post_reset: in_ready=%b busy=%b expected 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    int d0 = dut_drive_cnt;
    bit ok; logic [19:0] obs, e; int n;
    out_ready = 1'b1;
    push_one(16'h4400, expect_of(16'h4400));
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b expected 1", busy); end
    wait_out(ok, obs);
    e = exp_q.pop_front();
    checks++;
    if (!ok || obs !== e) begin failures++; $display("FAIL basic_4p0: got %h seen=%0d expected %h", obs, ok, e); end
    checks++;
    if (dut_drive_cnt - d0 != 1) begin
      failures++; $display("FAIL basic_drive_len: got %0d cycles expected 1", dut_drive_cnt - d0);
    end
    out_ready = 1'b0;
    push_one(16'h4C00, expect_of(16'h4C00));
    push_one(16'h3C00, expect_of(16'h3C00));
    push_one(16'h5400, expect_of(16'h5400));
    push_one(16'h4000, expect_of(16'h4000));
    out_ready = 1'b1;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      wait_out(ok, obs);
      e = exp_q.pop_front();
      checks++;
      if (!ok || obs !== e) begin failures++; $display("FAIL basic_seq[%0d]: got %h seen=%0d expected %h", k, obs, ok, e); end
    end
    checks++;
    if (dut_drive_cnt - d0 != 5) begin
      failures++; $display("FAIL basic_drive_total: got %0d cycles expected 5", dut_drive_cnt - d0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_special();
    bit ok; logic [19:0] obs, e; int n;
    out_ready = 1'b0;
    push_one(16'hBC00, {4'b0001, 16'h7E00});
    push_one(16'h7C00, {4'b0010, 16'h7C00});
    push_one(16'hFC00, {4'b0100, 16'hFC00});
    push_one(16'h7E00, {4'b0001, 16'h7E00});
    out_ready = 1'b1;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      wait_out(ok, obs);
      e = exp_q.pop_front();
      checks++;
      if (!ok || obs !== e) begin failures++; $display("FAIL special[%0d]: got %h seen=%0d expected %h", k, obs, ok, e); end
    end
  endtask

  task automatic test_timeout();
    int en_cnt = 0; bit seen = 1'b0; logic en_at = 1'b1;
    logic [19:0] obs = 20'h0, e;
    model_silent = 1'b1;
    out_ready = 1'b1;
    push_one(16'h4400, {4'b1000, 16'h7E00});
    for (int c = 0; c < 200 && !seen; c++) begin
      if (out_valid) begin
        seen = 1'b1; obs = {out_flags, out_data}; en_at = sq_enable;
      end else begin
        if (sq_enable) en_cnt++;
        @(negedge clk);
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (!seen || obs !== e) begin failures++; $display("FAIL timeout_code: got %h seen=%0d expected %h", obs, seen, e); end
    checks++;
    if (en_cnt != 65) begin failures++; $display("FAIL timeout_len: got %0d enable cycles expected 65", en_cnt); end
    checks++;
    if (en_at !== 1'b0) begin failures++; $display("FAIL timeout_release: enable=%b expected 0", en_at); end
    @(negedge clk);
    checks++;
    if (sq_enable !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL timeout_after: enable=%b out_valid=%b expected 0 0", sq_enable, out_valid);
    end
    model_silent = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] ops [6] = '{16'h4400, 16'h4C00, 16'h3C00, 16'h5400, 16'h5C00, 16'h4000};
    int idx = 0; int l0 = loads; bit acc, ok; logic [19:0] obs, e; int n;
    out_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      in_valid = (idx < 6);
      in_data = ops[(idx < 6) ? idx : 5];
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) begin exp_q.push_back(expect_of(ops[idx])); idx++; end
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 5 || in_ready !== 1'b0) begin
      failures++; $display("FAIL b2b_full: accepted=%0d in_ready=%b expected 5 0", idx, in_ready);
    end
    checks++;
    if (loads - l0 != 1 || out_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_hold: launches=%0d out_valid=%b expected 1 1", loads - l0, out_valid);
    end
    out_ready = 1'b1;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      wait_out(ok, obs);
      e = exp_q.pop_front();
      checks++;
      if (!ok || obs !== e) begin failures++; $display("FAIL b2b_drain[%0d]: got %h seen=%0d expected %h", k, obs, ok, e); end
    end
    push_one(ops[5], expect_of(ops[5]));
    wait_out(ok, obs);
    e = exp_q.pop_front();
    checks++;
    if (!ok || obs !== e) begin failures++; $display("FAIL b2b_sixth: got %h seen=%0d expected %h", obs, ok, e); end
  endtask

  task automatic test_reset_mid();
    int l0;
    model_silent = 1'b1;
    out_ready = 1'b1;
    push_one(16'h4400, 20'h0);
    push_one(16'h4C00, 20'h0);
    push_one(16'h3C00, 20'h0);
    exp_q.delete();
    repeat (5) @(negedge clk);
    checks++;
    if (sq_enable !== 1'b1) begin failures++; $display("FAIL rstmid_wait: enable=%b expected 1", sq_enable); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sq_enable, out_valid, busy, in_ready} !== 4'b0000 || !bus_idle(sq_data)) begin
      failures++; $display("FAIL rstmid_async: ctrl=%b bus=%h expected 0000 Z",
                           {sq_enable, out_valid, busy, in_ready}, sq_data);
    end
    model_silent = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    l0 = loads;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL rstmid_release: busy=%b in_ready=%b expected 0 1", busy, in_ready);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (loads != l0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rstmid_empty: launches=%0d out_valid=%b busy=%b expected 0 0 0",
                           loads - l0, out_valid, busy);
    end
  endtask

  task automatic test_wrap();
    bit ok; logic [19:0] obs, e; int n;
    out_ready = 1'b0;
    push_one(16'h4400, expect_of(16'h4400));
    push_one(16'h4C00, expect_of(16'h4C00));
    push_one(16'h3C00, expect_of(16'h3C00));
    push_one(16'h5400, expect_of(16'h5400));
    repeat (10) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      failures++; $display("FAIL wrap_setup: out_valid=%b in_ready=%b expected 1 1", out_valid, in_ready);
    end
    in_valid = 1'b1; in_data = 16'h5C00; out_ready = 1'b1;
    obs = {out_flags, out_data};
    e = exp_q.pop_front();
    exp_q.push_back(expect_of(16'h5C00));
    checks++;
    if (obs !== e) begin failures++; $display("FAIL wrap_first: got %h expected %h", obs, e); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL wrap_count3: in_ready=%b expected 1", in_ready); end
    push_one(16'h4000, expect_of(16'h4000));
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL wrap_count4: in_ready=%b expected 0", in_ready); end
    out_ready = 1'b1;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      wait_out(ok, obs);
      e = exp_q.pop_front();
      checks++;
      if (!ok || obs !== e) begin failures++; $display("FAIL wrap_order[%0d]: got %h seen=%0d expected %h", k, obs, ok, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    checks++;
    if (push_lost != 0) begin failures++; $display("FAIL push_accept: lost=%0d expected 0", push_lost); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
